sha256_round_ctrl: RTL and testbench

//  Sequencer for the iterative SHA-256 compression round unit (one round per issue, word[7]=a ... word[0]=h).

---
 rtl/sha256_round_ctrl.sv | 151 +++++++++++++++
 tb/tb_sha256_round_ctrl.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_round_ctrl.sv
// SHA-256 round sequencer: message schedule, round issue and digest forming.
// Define SHA_CTRL_DIGEST_ADD_EN to add the chaining IV into the digest.
module sha256_round_ctrl #(
    parameter int WORD_NUM  = 8,
    parameter int DATA_WID  = 32,
    parameter int ROUND_NUM = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [2*WORD_NUM*DATA_WID-1:0]        iv_msg,
    input  logic [WORD_NUM*DATA_WID-1:0]          iv_iv,
    input  logic                                  i_start_vld,
    output logic                                  o_start_rdy,
    output logic [WORD_NUM*DATA_WID-1:0]          ov_rnd_h_data,
    output logic                                  o_rnd_h_vld,
    output logic [DATA_WID-1:0]                   ov_rnd_w_data,
    output logic                                  o_rnd_w_vld,
    output logic [$clog2(ROUND_NUM)-1:0]          ov_k_idx,
    input  logic [WORD_NUM*DATA_WID-1:0]          iv_rnd_h_data,
    input  logic                                  i_rnd_h_vld,
    output logic [WORD_NUM*DATA_WID-1:0]          ov_digest,
    output logic                                  o_digest_vld,
    output logic                                  o_busy
);
    localparam int HW = WORD_NUM * DATA_WID;
    localparam int KW = $clog2(ROUND_NUM);

    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

    function automatic logic [DATA_WID-1:0] ror(logic [DATA_WID-1:0] x, int n);
        return (x >> n) | (x << (DATA_WID - n));
    endfunction

    function automatic logic [DATA_WID-1:0] sig0(logic [DATA_WID-1:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_WID-1:0] sig1(logic [DATA_WID-1:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction

    state_t              state;
    logic [HW-1:0]       iv_q;
    logic [HW-1:0]       fin_q;
    logic [DATA_WID-1:0] w_q [16];
    logic [KW-1:0]       rnd;
    logic                first;
    logic                outst;
    logic                last;

    logic [DATA_WID-1:0] w_new;
    logic                issue;
    logic [HW-1:0]       issue_h;
    logic [HW-1:0]       dig;

    // w_q[0] is W[t]; w_q[15] refills with W[t+16]
    assign w_new = sig1(w_q[14]) + w_q[9] + sig0(w_q[1]) + w_q[0];

    always_comb begin
        issue   = 1'b0;
        issue_h = iv_rnd_h_data;
        if (state == RUN) begin
            if (first) begin
                issue   = 1'b1;
                issue_h = iv_q;
            end else if (outst && i_rnd_h_vld && !last) begin
                issue = 1'b1;
            end
        end
    end

    always_comb begin
        dig = fin_q;
`ifdef SHA_CTRL_DIGEST_ADD_EN
        for (int i = 0; i < WORD_NUM; i++)
            dig[i*DATA_WID +: DATA_WID] = fin_q[i*DATA_WID +: DATA_WID]
                                        + iv_q[i*DATA_WID +: DATA_WID];
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            iv_q          <= '0;
            fin_q         <= '0;
            rnd           <= '0;
            first         <= 1'b0;
            outst         <= 1'b0;
            last          <= 1'b0;
            o_start_rdy   <= 1'b1;
            ov_rnd_h_data <= '0;
            o_rnd_h_vld   <= 1'b0;
            ov_rnd_w_data <= '0;
            o_rnd_w_vld   <= 1'b0;
            ov_k_idx      <= '0;
            ov_digest     <= '0;
            o_digest_vld  <= 1'b0;
            o_busy        <= 1'b0;
            for (int i = 0; i < 16; i++) w_q[i] <= '0;
        end else begin
            o_rnd_h_vld  <= 1'b0;
            o_rnd_w_vld  <= 1'b0;
            o_digest_vld <= 1'b0;
            if (issue) begin
                ov_rnd_h_data <= issue_h;
                ov_rnd_w_data <= w_q[0];
                ov_k_idx      <= rnd;
                o_rnd_h_vld   <= 1'b1;
                o_rnd_w_vld   <= 1'b1;
                first         <= 1'b0;
                outst         <= 1'b1;
                for (int i = 0; i < 15; i++) w_q[i] <= w_q[i+1];
                w_q[15] <= w_new;
                if (rnd == KW'(ROUND_NUM - 1)) last <= 1'b1;
                else rnd <= rnd + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (i_start_vld && o_start_rdy) begin
                        state       <= RUN;
                        o_start_rdy <= 1'b0;
                        o_busy      <= 1'b1;
                        iv_q        <= iv_iv;
                        rnd         <= '0;
                        first       <= 1'b1;
                        outst       <= 1'b0;
                        last        <= 1'b0;
                        for (int i = 0; i < 16; i++)
                            w_q[i] <= iv_msg[(15-i)*DATA_WID +: DATA_WID];
                    end
                end
                RUN: begin
                    if (!first && outst && i_rnd_h_vld && last) begin
                        fin_q <= iv_rnd_h_data;
                        outst <= 1'b0;
                        state <= FINAL;
                    end
                end
                FINAL: begin
                    ov_digest    <= dig;
                    o_digest_vld <= 1'b1;
                    o_start_rdy  <= 1'b1;
                    o_busy       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: golden round unit, K ROM and SHA-256 reference.
`timescale 1ns/1ps
module tb_sha256_round_ctrl;

`ifdef SHA_CTRL_DIGEST_ADD_EN
    localparam bit ADD = 1'b1;
`else
    localparam bit ADD = 1'b0;
`endif

    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [255:0] H0 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [255:0] ABC_STD =
        256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [511:0] ABC = {32'h61626380, 448'h0, 32'h00000018};

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [511:0] iv_msg = '0;
    logic [255:0] iv_iv = '0;
    logic         i_start_vld = 1'b0;
    logic         o_start_rdy;
    logic [255:0] ov_rnd_h_data;
    logic         o_rnd_h_vld;
    logic [31:0]  ov_rnd_w_data;
    logic         o_rnd_w_vld;
    logic [5:0]   ov_k_idx;
    logic [255:0] iv_rnd_h_data = '0;
    logic         i_rnd_h_vld = 1'b0;
    logic [255:0] ov_digest;
    logic         o_digest_vld;
    logic         o_busy;

    sha256_round_ctrl dut (
        .clk(clk), .rst(rst), .iv_msg(iv_msg), .iv_iv(iv_iv),
        .i_start_vld(i_start_vld), .o_start_rdy(o_start_rdy),
        .ov_rnd_h_data(ov_rnd_h_data), .o_rnd_h_vld(o_rnd_h_vld),
        .ov_rnd_w_data(ov_rnd_w_data), .o_rnd_w_vld(o_rnd_w_vld),
        .ov_k_idx(ov_k_idx), .iv_rnd_h_data(iv_rnd_h_data),
        .i_rnd_h_vld(i_rnd_h_vld), .ov_digest(ov_digest),
        .o_digest_vld(o_digest_vld), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;
    logic [255:0] abc_exp;
    logic [31:0]  ref_w [64];

    int           iss_k [$];
    logic [31:0]  iss_w [$];
    bit           overlap = 0;
    bit           wmis = 0;
    bit           rand_lat = 0;
    bit           stray = 0;
    int           first_iss = -1;
    int           ru_cnt = 0;
    logic [255:0] ru_res = '0;

    function automatic logic [31:0] ror(logic [31:0] x, int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ss0(logic [31:0] x);
        return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ss1(logic [31:0] x);
        return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [31:0] bs0(logic [31:0] x);
        return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
    endfunction
    function automatic logic [31:0] bs1(logic [31:0] x);
        return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
    endfunction

    // Golden round unit: one SHA-256 round on packed state {a..h}
    function automatic logic [255:0] rnd_fn(logic [255:0] h, logic [31:0] w,
                                            logic [31:0] k);
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        {a, b, c, d, e, f, g, hh} = h;
        t1 = hh + bs1(e) + ((e & f) ^ (~e & g)) + k + w;
        t2 = bs0(a) + ((a & b) ^ (a & c) ^ (b & c));
        return {t1 + t2, a, b, c, d + t1, e, f, g};
    endfunction

    // Whole-block reference: full schedule array, then 64 rounds on a state array
    task automatic ref_model(input logic [511:0] m, input logic [255:0] iv,
                             output logic [255:0] dig);
        logic [31:0] s [8];
        logic [31:0] t1, t2;
        for (int i = 0; i < 16; i++) ref_w[i] = m[511-32*i -: 32];
        for (int i = 16; i < 64; i++)
            ref_w[i] = ss1(ref_w[i-2]) + ref_w[i-7] + ss0(ref_w[i-15]) + ref_w[i-16];
        for (int i = 0; i < 8; i++) s[i] = iv[255-32*i -: 32];
        for (int t = 0; t < 64; t++) begin
            t1 = s[7] + bs1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + KT[t] + ref_w[t];
            t2 = bs0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
            for (int j = 7; j > 0; j--) s[j] = s[j-1];
            s[4] = s[4] + t1;
            s[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++)
            dig[255-32*i -: 32] = s[i] + (ADD ? iv[255-32*i -: 32] : 32'h0);
    endtask

    always @(negedge clk) begin
        i_rnd_h_vld = 1'b0;
        if (rst) begin
            ru_cnt = 0;
        end else begin
            if (o_rnd_w_vld !== o_rnd_h_vld) wmis = 1;
            if (o_rnd_h_vld === 1'b1) begin
                if (ru_cnt != 0) overlap = 1;
                if (iss_k.size() == 0) first_iss = cyc;
                iss_k.push_back(int'(ov_k_idx));
                iss_w.push_back(ov_rnd_w_data);
                ru_res = rnd_fn(ov_rnd_h_data, ov_rnd_w_data, KT[ov_k_idx]);
                ru_cnt = rand_lat ? int'($urandom_range(1, 5)) : 1;
            end
            if (ru_cnt != 0) begin
                ru_cnt--;
                if (ru_cnt == 0) begin
                    i_rnd_h_vld   = 1'b1;
                    iv_rnd_h_data = ru_res;
                end
            end
            if (stray) begin
                i_rnd_h_vld   = 1'b1;
                iv_rnd_h_data = {8{$urandom()}};
            end
        end
    end

    task automatic start_block(input logic [511:0] m, input logic [255:0] iv,
                               output int e0, output bit tmo);
        int n = 0;
        @(negedge clk);
        iss_k.delete();
        iss_w.delete();
        overlap   = 0;
        wmis      = 0;
        first_iss = -1;
        iv_msg = m;
        iv_iv  = iv;
        i_start_vld = 1'b1;
        while (!o_start_rdy && n < 500) begin
            @(negedge clk);
            n++;
        end
        tmo = !o_start_rdy;
        @(negedge clk);
        e0 = cyc;
        i_start_vld = 1'b0;
    endtask

    task automatic wait_digest(output int dc, output logic [255:0] d, output bit tmo);
        int n = 0;
        while (!o_digest_vld && n < 2000) begin
            @(negedge clk);
            n++;
        end
        tmo = !o_digest_vld;
        dc  = cyc;
        d   = ov_digest;
    endtask

    function automatic logic [511:0] rand_msg();
        logic [511:0] m = '0;
        for (int i = 0; i < 16; i++) m = {m[479:0], $urandom()};
        return m;
    endfunction

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({o_start_rdy, o_rnd_h_vld, o_rnd_w_vld, o_digest_vld, o_busy} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_flags got %b want 10000",
                     {o_start_rdy, o_rnd_h_vld, o_rnd_w_vld, o_digest_vld, o_busy});
        end
        checks++;
        if (ov_k_idx !== 6'd0 || ov_digest !== 256'h0) begin
            errors++;
            $display("FAIL reset_data k %0d digest %h want 0", ov_k_idx, ov_digest);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (o_start_rdy !== 1'b1 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset rdy %b busy %b want 1 0", o_start_rdy, o_busy);
        end
    endtask

    task automatic test_abc();
        int e0, dc;
        bit tmo, tmo2, ok;
        logic [255:0] d, r;
        ref_model(ABC, H0, r);
        rand_lat = 0;
        start_block(ABC, H0, e0, tmo);
        wait_digest(dc, d, tmo2);
        checks++;
        if (tmo || tmo2 || d !== abc_exp) begin
            errors++;
            $display("FAIL abc_digest got %h want %h", d, abc_exp);
        end
        checks++;
        if (dc - e0 != 66 || first_iss - e0 != 1) begin
            errors++;
            $display("FAIL abc_latency digest %0d first %0d want 66 1", dc - e0, first_iss - e0);
        end
        checks++;
        if (iss_k.size() != 64) begin
            errors++;
            $display("FAIL abc_issue_count got %0d want 64", iss_k.size());
        end
        ok = (iss_k.size() == 64) && (iss_w.size() == 64);
        for (int i = 0; i < iss_k.size() && i < 64; i++)
            if (iss_k[i] != i || iss_w[i] !== ref_w[i]) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL abc_k_w_sequence got wrong k index or W word");
        end
        checks++;
        if (wmis) begin
            errors++;
            $display("FAIL w_vld_tracks_h_vld got mismatch want equal");
        end
        repeat (5) @(negedge clk);
        checks++;
        if (ov_digest !== abc_exp || o_digest_vld !== 1'b0) begin
            errors++;
            $display("FAIL digest_hold got %h vld %b want %h 0", ov_digest, o_digest_vld, abc_exp);
        end
    endtask

    task automatic test_random_latency();
        int e0, dc;
        bit tmo, tmo2, ok;
        logic [511:0] m;
        logic [255:0] iv, d, r;
        for (int it = 0; it < 4; it++) begin
            m  = (it == 0) ? ABC : rand_msg();
            iv = (it == 0) ? H0 : {8{$urandom()}};
            ref_model(m, iv, r);
            rand_lat = 1;
            start_block(m, iv, e0, tmo);
            wait_digest(dc, d, tmo2);
            checks++;
            if (tmo || tmo2 || d !== r) begin
                errors++;
                $display("FAIL stall_digest[%0d] got %h want %h", it, d, r);
            end
            ok = (iss_k.size() == 64) && !overlap;
            for (int i = 0; i < iss_k.size() && i < 64; i++)
                if (iss_k[i] != i || iss_w[i] !== ref_w[i]) ok = 0;
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL stall_issue[%0d] count %0d overlap %0d want 64 0",
                         it, iss_k.size(), overlap);
            end
        end
        rand_lat = 0;
    endtask

    task automatic test_back_to_back();
        int e0a, e0b, dc;
        bit tmo, tmo2;
        logic [511:0] mb;
        logic [255:0] ivb, rb, d;
        mb  = rand_msg();
        ivb = {8{$urandom()}};
        ref_model(mb, ivb, rb);
        rand_lat = 0;
        start_block(ABC, H0, e0a, tmo);
        iv_msg = mb;
        iv_iv  = ivb;
        i_start_vld = 1'b1;
        wait_digest(dc, d, tmo2);
        checks++;
        if (tmo || tmo2 || d !== abc_exp) begin
            errors++;
            $display("FAIL b2b_first got %h want %h", d, abc_exp);
        end
        @(negedge clk);
        e0b = cyc;
        i_start_vld = 1'b0;
        checks++;
        if (e0b - e0a != 67 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_accept gap %0d busy %b want 67 1", e0b - e0a, o_busy);
        end
        wait_digest(dc, d, tmo2);
        checks++;
        if (tmo2 || d !== rb || dc - e0b != 66) begin
            errors++;
            $display("FAIL b2b_second got %h at %0d want %h at 66", d, dc - e0b, rb);
        end
    endtask

    task automatic test_reset_mid();
        int e0, dc, n;
        bit tmo, tmo2;
        logic [255:0] d;
        rand_lat = 0;
        start_block(ABC, H0, e0, tmo);
        n = 0;
        while (iss_k.size() < 30 && n < 500) begin
            @(negedge clk);
            n++;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({o_start_rdy, o_rnd_h_vld, o_rnd_w_vld, o_digest_vld, o_busy} !== 5'b10000 ||
            ov_k_idx !== 6'd0 || ov_digest !== 256'h0) begin
            errors++;
            $display("FAIL mid_reset flags %b k %0d digest %h want 10000 0 0",
                     {o_start_rdy, o_rnd_h_vld, o_rnd_w_vld, o_digest_vld, o_busy},
                     ov_k_idx, ov_digest);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        start_block(ABC, H0, e0, tmo);
        wait_digest(dc, d, tmo2);
        checks++;
        if (tmo || tmo2 || d !== abc_exp || iss_k.size() != 64 || dc - e0 != 66) begin
            errors++;
            $display("FAIL restart_digest got %h n %0d want %h n 64", d, iss_k.size(), abc_exp);
        end
    endtask

    task automatic test_ignored_inputs();
        int e0, dc, n;
        bit tmo, tmo2, ok;
        logic [255:0] d;
        bit rdy_seen;
        rand_lat = 0;
        @(negedge clk);
        iss_k.delete();
        stray = 1;
        repeat (4) @(negedge clk);
        stray = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (iss_k.size() != 0 || o_busy !== 1'b0 || o_digest_vld !== 1'b0) begin
            errors++;
            $display("FAIL stray_idle issues %0d busy %b want 0 0", iss_k.size(), o_busy);
        end
        start_block(ABC, H0, e0, tmo);
        n = 0;
        while (iss_k.size() < 10 && n < 500) begin
            @(negedge clk);
            n++;
        end
        iv_msg = rand_msg();
        iv_iv  = {8{$urandom()}};
        i_start_vld = 1'b1;
        rdy_seen = o_start_rdy;
        @(negedge clk);
        i_start_vld = 1'b0;
        checks++;
        if (rdy_seen !== 1'b0 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start rdy %b busy %b want 0 1", rdy_seen, o_busy);
        end
        wait_digest(dc, d, tmo2);
        checks++;
        if (tmo || tmo2 || d !== abc_exp) begin
            errors++;
            $display("FAIL pulse_digest got %h want %h", d, abc_exp);
        end
        ok = iss_k.size() == 64;
        for (int i = 0; i < iss_k.size() && i < 64; i++)
            if (iss_k[i] != i) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL pulse_k_sequence count %0d want 64 unbroken", iss_k.size());
        end
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_start_rdy !== 1'b1) begin
            errors++;
            $display("FAIL pulse_no_restart busy %b rdy %b want 0 1", o_busy, o_start_rdy);
        end
    endtask

    initial begin
        logic [255:0] std, h0v;
        std = ABC_STD;
        h0v = H0;
        for (int i = 0; i < 8; i++)
            abc_exp[32*i +: 32] = ADD ? std[32*i +: 32]
                                      : std[32*i +: 32] - h0v[32*i +: 32];
        test_reset();
        test_abc();
        test_random_latency();
        test_back_to_back();
        test_reset_mid();
        test_ignored_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
